// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : timer_arbiter
// Description : Round-robin arbiter that lends one shared 8-bit up-counter to
//               two requesters and pulses a per-port done at terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] len0,
    input  logic [7:0] len1,
    input  logic       abort,
    output logic [1:0] gnt,
    output logic       busy,
    output logic [7:0] count,
    output logic       done0,
    output logic       done1
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_gnt;
    logic [1:0] w_gnt_next;
    logic [7:0] r_count;
    logic [7:0] w_count_next;
    logic [7:0] r_target;
    logic [7:0] w_target_next;
    logic       r_last;
    logic       w_last_next;
    logic       w_pick1;

    // r_last holds the index of the port served most recently; on a tie the
    // other port wins. Reset value 1 gives port 0 first priority.
    assign w_pick1 = req1 && (!req0 || !r_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_gnt    <= 2'b00;
            r_count  <= 8'd0;
            r_target <= 8'd0;
            r_last   <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_gnt    <= w_gnt_next;
            r_count  <= w_count_next;
            r_target <= w_target_next;
            r_last   <= w_last_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_gnt_next    = r_gnt;
        w_count_next  = r_count;
        w_target_next = r_target;
        w_last_next   = r_last;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_state_next  = S_RUN;
                    w_gnt_next    = w_pick1 ? 2'b10 : 2'b01;
                    w_count_next  = 8'd0;
                    w_target_next = w_pick1 ? len1 : len0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_gnt_next   = 2'b00;
                    w_last_next  = r_gnt[1];
                end else if (r_count == r_target) begin
                    // Terminal count reached: hold the value, never wrap.
                    w_state_next = S_DONE;
                end else begin
                    w_count_next = r_count + 8'd1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_gnt_next   = 2'b00;
                w_last_next  = r_gnt[1];
            end
            default: begin
                w_state_next = S_IDLE;
                w_gnt_next   = 2'b00;
            end
        endcase
    end

    assign gnt   = r_gnt;
    assign busy  = (r_state != S_IDLE);
    assign count = r_count;
    assign done0 = (r_state == S_DONE) && r_gnt[0];
    assign done1 = (r_state == S_DONE) && r_gnt[1];

endmodule
`default_nettype wire

// File: tb/tb_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_arbiter
// Description : Directed scoreboard bench for timer_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] len0, len1;
    logic       abort;
    logic [1:0] gnt;
    logic       busy;
    logic [7:0] count;
    logic       done0, done1;

    timer_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .len0  (len0),
        .len1  (len1),
        .abort (abort),
        .gnt   (gnt),
        .busy  (busy),
        .count (count),
        .done0 (done0),
        .done1 (done1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] gnt;
        logic       busy;
        logic [7:0] count;
        logic       d0;
        logic       d1;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation stamped for the current cycle.
    always @(negedge clk) begin
        checks++;
        if (!$onehot0(gnt)) begin
            errors++;
            $display("FAIL gnt_onehot cyc%0d got gnt=%b required one-hot or zero", cyc, gnt);
        end
        checks++;
        if (done0 && done1) begin
            errors++;
            $display("FAIL done_exclusive cyc%0d got done0=1 done1=1 required not both", cyc);
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_check cyc%0d expectation never compared", e.cyc);
        end
        while (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            checks++;
            if ({gnt, busy, count, done0, done1} !== {e.gnt, e.busy, e.count, e.d0, e.d1}) begin
                errors++;
                $display("FAIL outputs cyc%0d got gnt=%b busy=%b count=%0d d0=%b d1=%b required gnt=%b busy=%b count=%0d d0=%b d1=%b",
                         cyc, gnt, busy, count, done0, done1, e.gnt, e.busy, e.count, e.d0, e.d1);
            end
        end
    end

    task automatic push(input int c, input logic [1:0] g, input logic b,
                        input logic [7:0] cnt, input logic d0, input logic d1);
        exp_t x;
        x.cyc = c; x.gnt = g; x.busy = b; x.count = cnt; x.d0 = d0; x.d1 = d1;
        q.push_back(x);
    endtask

    // Full run of length len granted at sample cycle n to port p.
    task automatic run_expect(input int n, input int p, input int len);
        logic [1:0] g;
        logic [7:0] l8;
        logic [7:0] k8;
        g  = (p == 0) ? 2'b01 : 2'b10;
        l8 = len[7:0];
        for (int k = 0; k <= len; k++) begin
            k8 = k[7:0];
            push(n + 1 + k, g, 1'b1, k8, 1'b0, 1'b0);
        end
        push(n + len + 2, g, 1'b1, l8, (p == 0), (p == 1));
        push(n + len + 3, 2'b00, 1'b0, l8, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int t);
        while (cyc < t) step();
    endtask

    initial begin
        int c;
        logic [7:0] k8;
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        len0 = 8'd0; len1 = 8'd0; abort = 1'b0;
        step(); step();

        // Reset state
        c = cyc;
        push(c, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step();

        // V1: req0, len 3; len change during run must be ignored
        c = cyc;
        req0 = 1'b1; len0 = 8'd3;
        run_expect(c, 0, 3);
        step();
        req0 = 1'b0; len0 = 8'd50;
        at_cycle(c + 7);

        // V3: req1, len 0
        c = cyc;
        req1 = 1'b1; len1 = 8'd0;
        run_expect(c, 1, 0);
        step();
        req1 = 1'b0;
        at_cycle(c + 4);

        // V2: both held -> 0,1,0,1 with one IDLE cycle between grants
        c = cyc;
        req0 = 1'b1; req1 = 1'b1; len0 = 8'd1; len1 = 8'd2;
        run_expect(c,      0, 1);
        run_expect(c + 4,  1, 2);
        run_expect(c + 9,  0, 1);
        run_expect(c + 13, 1, 2);
        at_cycle(c + 18);
        req0 = 1'b0; req1 = 1'b0;
        step();

        // V4: abort at count 5, then tie goes to port 1; abort in DONE ignored
        c = cyc;
        req0 = 1'b1; len0 = 8'd10;
        for (int k = 0; k <= 5; k++) begin
            k8 = k[7:0];
            push(c + 1 + k, 2'b01, 1'b1, k8, 1'b0, 1'b0);
        end
        push(c + 7, 2'b00, 1'b0, 8'd5, 1'b0, 1'b0);
        step();
        req0 = 1'b0;
        at_cycle(c + 6);
        abort = 1'b1;
        step();
        abort = 1'b0; req0 = 1'b1; req1 = 1'b1; len1 = 8'd2;
        run_expect(c + 7, 1, 2);
        step();
        req0 = 1'b0; req1 = 1'b0;
        at_cycle(c + 11);
        abort = 1'b1;
        step();
        abort = 1'b0;
        at_cycle(c + 13);

        // V5: len 0xFF, no wrap, done at +257
        c = cyc;
        req0 = 1'b1; len0 = 8'hFF;
        run_expect(c, 0, 255);
        step();
        req0 = 1'b0;
        at_cycle(c + 259);

        // V6: reset mid-run at count 4, then tie goes to port 0
        c = cyc;
        req0 = 1'b1; len0 = 8'd10;
        for (int k = 0; k <= 4; k++) begin
            k8 = k[7:0];
            push(c + 1 + k, 2'b01, 1'b1, k8, 1'b0, 1'b0);
        end
        push(c + 6, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0);
        step();
        req0 = 1'b0;
        at_cycle(c + 5);
        reset = 1'b1;
        step();
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1; len0 = 8'd1; len1 = 8'd3;
        run_expect(c + 6, 0, 1);
        step();
        req0 = 1'b0; req1 = 1'b0;
        at_cycle(c + 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
